inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Fetch stage directly upstream of the instruction decode/control unit.
- Owns the program counter and issues word requests to instruction memory over a req/ready handshake.
- Registers the returned instruction and its PC for decode, and holds them while `stall` is high.
- Accepts PC redirects (jump/branch) from downstream and discards stale in-flight fetches.

Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `NOP_INST`, 32'h0000_0013, instruction driven when no valid instruction (addi x0,x0,0).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  downstream cannot accept; hold output register.
- `branchEn`  in  1  redirect request from control (1 = take `branchTarget`).
- `branchTarget`  in  32  redirect PC.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch word address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready`  in  1  memory completes request this cycle; `imem_rdata` valid.
- `imem_rdata`  in  32  fetched instruction.
- `inst`  out  32  instruction to decode.
- `inst_pc`  out  32  PC of `inst`.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a real instruction.
- `misalign`  out  1  one-cycle pulse: `branchTarget[1:0]` != 0 on an accepted redirect.

Behaviour:
- Reset (async, immediate):
  - pc=`RESET_PC`, req_addr=`RESET_PC`, state=IDLE.
  - `imem_req`=0, `inst`=`NOP_INST`, `inst_pc`=0, `inst_valid`=0, `misalign`=0.
- Consume rule: the output register is consumed at a rising edge where `inst_valid`=1 and `stall`=0.
- Slot free: `inst_valid`=0 OR the output is consumed this edge.
- States:
  - IDLE: `imem_req`=0.
    - If slot free: next=REQ, req_addr<=pc.
    - Else next=HOLD.
  - REQ: `imem_req`=1, `imem_addr`=req_addr.
    - On `imem_ready`=1 (no redirect): `inst`<=`imem_rdata`, `inst_pc`<=req_addr, `inst_valid`<=1, pc<=req_addr+4.
    - If slot still free next cycle (i.e. `stall`=0): stay REQ with req_addr<=req_addr+4 (back-to-back fetch, 1 instruction/cycle at zero-wait memory).
    - Otherwise go HOLD.
  - HOLD: `imem_req`=0.
    - Outputs hold while `stall`=1.
    - When `stall`=0: go REQ, req_addr<=pc.
  - KILL: `imem_req`=1 with the old req_addr, which stays stable.
    - On `imem_ready`: discard `imem_rdata`, go REQ with req_addr<=pc (the redirected target).
- Redirect: `branchEn`=1 with `stall`=0 at an edge.
  - pc<={`branchTarget[31:2]`,2'b00}.
  - `inst_valid`<=0 and `inst`<=`NOP_INST` (flush).
  - `misalign`<=|`branchTarget[1:0]`.
- Redirect by state:
  - REQ with `imem_ready`=1 same cycle: response dropped, next=REQ with req_addr<=target.
  - REQ with `imem_ready`=0: next=KILL.
  - IDLE/HOLD: next=REQ with req_addr<=target.
  - KILL: pc overwritten with the newest target; stay KILL.
- `branchEn` while `stall`=1 is ignored; control re-asserts it when the stall is released.
- `imem_req` never drops while a request is outstanding (REQ/KILL until `imem_ready`).
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC+4 -> 32'h0000_0000, no flag.
- `imem_ready` while `imem_req`=0 is ignored.
- Reset asserted mid-request: abandon immediately. The memory side must tolerate a dropped request.
- Latency: `imem_ready` at edge N -> `inst_valid`=1 after edge N.

Test Plan:
- Reset release, zero-wait memory (`imem_ready` tied 1, rdata=addr^32'hA5A5_0000):
  - `imem_addr` sequence 0,4,8,C on consecutive cycles.
  - `inst_pc` follows one cycle later; `inst_valid`=1 continuously.
- Stall 3 cycles while `inst_pc`=8:
  - `inst`/`inst_pc` hold for 3 cycles; `imem_req`=0 during HOLD.
  - Resume fetching at 32'h10; no address skipped or duplicated.
- Memory with 2 wait states: `imem_addr` stable for 3 cycles per request; `inst_valid`=0 between responses.
- `branchEn`=1, `branchTarget`=32'h100 while a request to 32'h14 is pending with 2 wait states:
  - KILL; response for 32'h14 never appears on `inst`.
  - Next `imem_addr`=32'h100; first valid `inst_pc`=32'h100.
- `branchTarget`=32'h203 with `stall`=0: `misalign` pulses 1 cycle; fetch from 32'h200.
- PC wrap and async reset:
  - Redirect to 32'hFFFF_FFFC: next fetch 32'h0.
  - Asserting `rst` mid-cycle: `inst_valid`=0, `imem_req`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
//
// Fetch stage that sits directly in front of instruction decode. It owns the
// program counter and issues one word request at a time to instruction memory
// over a req/ready handshake. It registers each returned instruction together
// with its PC for decode, and holds that register while decode stalls. Decode
// can redirect the PC. Any fetch that is still in flight when a redirect
// arrives is allowed to finish, and its data is dropped.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous, active-high reset
//   stall        in   1   decode cannot accept; output register holds
//   branchEn     in   1   redirect request (ignored while stall=1)
//   branchTarget in  32   redirect PC (low two bits only flag misalign)
//   imem_req     out  1   fetch request valid; stays high until imem_ready
//   imem_addr    out 32   fetch word address; stable while a request waits
//   imem_ready   in   1   memory completes the request this cycle
//   imem_rdata   in  32   fetched instruction, valid with imem_ready
//   inst         out 32   instruction to decode (NOP_INST when invalid)
//   inst_pc      out 32   PC of inst
//   inst_valid   out  1   inst/inst_pc hold a real instruction
//   misalign     out  1   one-cycle pulse: accepted redirect target not
//                         word aligned
// ----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branchEn,
    input  logic [31:0] branchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // out of reset, nothing issued yet
        REQ  = 2'd1,   // request outstanding
        HOLD = 2'd2,   // no request; waiting for decode to accept
        KILL = 2'd3    // stale request outstanding; its data is discarded
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] req_addr, req_addr_nx;

    // One-entry park buffer. A memory response can land while decode stalls
    // on a valid instruction. The request cannot be withdrawn, so the data
    // waits here until the stall is released.
    logic        pend_valid;
    logic [31:0] pend_inst;
    logic [31:0] pend_pc;

    logic        slot_free;
    logic        redirect;
    logic [31:0] target;
    logic        resp;
    logic        capture;
    logic        park;
    logic        unpark;

    always_comb begin
        slot_free = !inst_valid || !stall;
        redirect  = branchEn && !stall;
        target    = {branchTarget[31:2], 2'b00};
        resp      = (state == REQ) && imem_ready;
        capture   = resp && !redirect && slot_free;
        park      = resp && !redirect && !slot_free;
        unpark    = (state == HOLD) && pend_valid && !stall;
    end

    assign imem_req  = (state == REQ) || (state == KILL);
    assign imem_addr = req_addr;

    // ------------------------------------------------------------------------
    // Next-state / PC logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first. A path that
        // leaves one unassigned would infer a latch.
        state_nx    = state;
        pc_nx       = pc;
        req_addr_nx = req_addr;

        unique case (state)
            IDLE: begin
                if (redirect) begin
                    pc_nx       = target;
                    req_addr_nx = target;
                    state_nx    = REQ;
                end else if (slot_free) begin
                    req_addr_nx = pc;
                    state_nx    = REQ;
                end else begin
                    state_nx = HOLD;
                end
            end

            REQ: begin
                if (redirect) begin
                    pc_nx = target;
                    if (imem_ready) begin
                        // Response lands with the redirect: drop it and
                        // fetch the new target straight away.
                        req_addr_nx = target;
                        state_nx    = REQ;
                    end else begin
                        state_nx = KILL;
                    end
                end else if (imem_ready) begin
                    pc_nx = req_addr + 32'd4;
                    if (!stall) begin
                        req_addr_nx = req_addr + 32'd4;
                        state_nx    = REQ;
                    end else begin
                        state_nx = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_nx       = target;
                    req_addr_nx = target;
                    state_nx    = REQ;
                end else if (!stall) begin
                    req_addr_nx = pc;
                    state_nx    = REQ;
                end
            end

            KILL: begin
                // req_addr stays on the stale address until memory answers.
                if (redirect) begin
                    pc_nx = target;
                end
                if (imem_ready) begin
                    req_addr_nx = redirect ? target : pc;
                    state_nx    = REQ;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            req_addr <= req_addr_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Decode-facing output register and park-buffer valid flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst       <= NOP_INST;
            inst_pc    <= 32'h0000_0000;
            inst_valid <= 1'b0;
            misalign   <= 1'b0;
            pend_valid <= 1'b0;
        end else begin
            misalign <= redirect && (branchTarget[1:0] != 2'b00);

            if (redirect) begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
                pend_valid <= 1'b0;
            end else if (capture) begin
                inst       <= imem_rdata;
                inst_pc    <= req_addr;
                inst_valid <= 1'b1;
            end else if (park) begin
                pend_valid <= 1'b1;
            end else if (unpark) begin
                inst       <= pend_inst;
                inst_pc    <= pend_pc;
                inst_valid <= 1'b1;
                pend_valid <= 1'b0;
            end else if (inst_valid && !stall) begin
                // Consumed with nothing new to show.
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
            end
        end
    end

    // NOTE: the park payload has no reset. pend_valid qualifies it, so
    // leaving the data registers unreset is safe and keeps them plain flops.
    always_ff @(posedge clk) begin
        if (park) begin
            pend_inst <= imem_rdata;
            pend_pc   <= req_addr;
        end
    end

endmodule
